// File: rtl/dds_wave_gen_if.sv
// Configuration port of dds_wave_gen: valid/ready retune request carrying the
// frequency tuning word, phase offset, waveform select and apply-at-wrap flag.
interface dds_wave_gen_if #(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 12
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ACC_W-1:0]  cfg_ftw;
    logic [ADDR_W-1:0] cfg_poff;
    logic [1:0]        cfg_wave;
    logic              cfg_sync;

    modport master (
        output cfg_valid, cfg_ftw, cfg_poff, cfg_wave, cfg_sync,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ftw, cfg_poff, cfg_wave, cfg_sync,
        output cfg_ready
    );
endinterface

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS waveform generator. Phase accumulator (S0), offset phase to the
// sine ROM address (S1), ROM read with delayed phase/wave (S2), waveform select (S3).
// Retune through a valid/ready port, applied immediately or at the next accumulator wrap.
// Optional feature: define DDS_DITHER_EN to add LFSR dither to the phase ahead of S1.
module dds_wave_gen #(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              en,
    dds_wave_gen_if.slave     cfg,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic              wrap_pulse
);

    typedef enum logic [1:0] {
        WaveSine   = 2'b00,
        WaveSquare = 2'b01,
        WaveTri    = 2'b10,
        WaveSaw    = 2'b11
    } wave_e;

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  acc_src;
    logic              carry;
    logic              carry_en;

    logic [ACC_W-1:0]  ftw_act_q;
    logic [ACC_W-1:0]  ftw_sh_q;
    logic [ADDR_W-1:0] poff_act_q;
    logic [ADDR_W-1:0] poff_sh_q;
    wave_e             wave_act_q;
    wave_e             wave_sh_q;

    logic              pend_q;
    logic              pend_d;
    logic              ready_q;
    logic              accept;
    logic              apply_sh;

    logic [ADDR_W-1:0] phase_s1;
    wave_e             wave_s1_q;
    logic              valid_s1_q;
    // Only the phase bits any computed waveform needs travel to S3.
    logic [DATA_W:0]   phase_s2_q;
    wave_e             wave_s2_q;
    logic              valid_s2_q;
    logic [DATA_W-1:0] tri_t;
    logic [DATA_W-1:0] sample;

    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, ftw_act_q};
    assign carry_en         = en & carry;
    assign cfg.cfg_ready    = ready_q;

    // S0: accumulator advances only when enabled; carry-out becomes the wrap pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            acc_q      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            if (en) begin
                acc_q <= acc_sum;
            end
            wrap_pulse <= carry_en;
        end
    end

    // Pending-config bookkeeping: a sync request waits for the next enabled carry.
    always_comb begin
        accept   = cfg.cfg_valid & ready_q;
        apply_sh = pend_q & carry_en;
        pend_d   = pend_q;
        if (apply_sh) begin
            pend_d = 1'b0;
        end else if (accept && cfg.cfg_sync) begin
            pend_d = 1'b1;
        end
    end

    // Active/shadow config registers; ready drops while a sync request is pending.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ftw_act_q  <= '0;
            poff_act_q <= '0;
            wave_act_q <= WaveSine;
            ftw_sh_q   <= '0;
            poff_sh_q  <= '0;
            wave_sh_q  <= WaveSine;
            pend_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ready_q <= ~pend_d;
            if (apply_sh) begin
                ftw_act_q  <= ftw_sh_q;
                poff_act_q <= poff_sh_q;
                wave_act_q <= wave_sh_q;
            end else if (accept) begin
                if (cfg.cfg_sync) begin
                    ftw_sh_q  <= cfg.cfg_ftw;
                    poff_sh_q <= cfg.cfg_poff;
                    wave_sh_q <= wave_e'(cfg.cfg_wave);
                end else begin
                    ftw_act_q  <= cfg.cfg_ftw;
                    poff_act_q <= cfg.cfg_poff;
                    wave_act_q <= wave_e'(cfg.cfg_wave);
                end
            end
        end
    end

`ifdef DDS_DITHER_EN
    localparam int unsigned DITH_W = ((ACC_W - ADDR_W) < 16) ? (ACC_W - ADDR_W) : 16;

    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11; free-running every cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign acc_src = acc_q + ACC_W'(lfsr_q[DITH_W-1:0]);
`else
    assign acc_src = acc_q;
`endif

    assign phase_s1 = acc_src[ACC_W-1 -: ADDR_W] + poff_act_q;

    // S1/S2: ROM address, then phase/wave/valid delayed to line up with rom_data.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rom_addr   <= '0;
            wave_s1_q  <= WaveSine;
            valid_s1_q <= 1'b0;
            phase_s2_q <= '0;
            wave_s2_q  <= WaveSine;
            valid_s2_q <= 1'b0;
        end else begin
            rom_addr   <= phase_s1;
            wave_s1_q  <= wave_act_q;
            valid_s1_q <= en;
            phase_s2_q <= rom_addr[ADDR_W-1 -: DATA_W+1];
            wave_s2_q  <= wave_s1_q;
            valid_s2_q <= valid_s1_q;
        end
    end

    // S3 waveform shaping from the aligned phase and ROM word.
    always_comb begin
        tri_t  = phase_s2_q[DATA_W-1:0];
        sample = '0;
        unique case (wave_s2_q)
            WaveSine:   sample = rom_data;
            WaveSquare: sample = {DATA_W{phase_s2_q[DATA_W]}};
            WaveTri:    sample = phase_s2_q[DATA_W] ? ~tri_t : tri_t;
            WaveSaw:    sample = phase_s2_q[DATA_W:1];
        endcase
    end

    // S3 output register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dac_data  <= '0;
            dac_valid <= 1'b0;
        end else begin
            dac_data  <= sample;
            dac_valid <= valid_s2_q;
        end
    end

endmodule
